// File: rtl/td4n_core.sv
// TD4-class CPU core with A/B registers, carry flag, PC and in/out ports.
// It has a writable program memory, run/stop/single-step control, HLT and an output-valid strobe.
module td4n_core #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W+3:0] prog_data,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              cflag,
  output logic [1:0]        state
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    StStop   = 2'b00,
    StRun    = 2'b01,
    StHalted = 2'b10
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] a_q, b_q, out_q;
  logic [ADDR_W-1:0] pc_q;
  logic              cflag_q, out_valid_q;

  logic [DATA_W+3:0] mem [Depth];

  logic [DATA_W+3:0] instr;
  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] src;
  logic [DATA_W:0]   sum;
  logic [ADDR_W-1:0] pc_next;
  logic              wr_a, wr_b, is_out, is_hlt, is_nop, jump, exec;

  always_comb begin
    instr  = mem[pc_q];
    op     = instr[3:0];
    imm    = instr[DATA_W+3:4];
    src    = '0;
    wr_a   = 1'b0;
    wr_b   = 1'b0;
    is_out = 1'b0;
    is_hlt = 1'b0;
    is_nop = 1'b0;
    jump   = 1'b0;
    case (op)
      4'b0000: begin src = a_q;     wr_a = 1'b1; end
      4'b0101: begin src = b_q;     wr_b = 1'b1; end
      4'b0011: wr_a = 1'b1;
      4'b0111: wr_b = 1'b1;
      4'b0001: begin src = b_q;     wr_a = 1'b1; end
      4'b0100: begin src = a_q;     wr_b = 1'b1; end
      4'b0010: begin src = in_port; wr_a = 1'b1; end
      4'b0110: begin src = in_port; wr_b = 1'b1; end
      4'b1001: begin src = b_q;     is_out = 1'b1; end
      4'b1011: is_out = 1'b1;
      4'b1111: jump = 1'b1;
      4'b1110: jump = ~cflag_q;
      4'b1000: is_hlt = 1'b1;
      default: is_nop = 1'b1;
    endcase
    sum     = {1'b0, src} + {1'b0, imm};
    pc_next = jump ? imm[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    // start takes priority over step while stopped
    exec    = ((state_q == StRun) && !stop) || ((state_q == StStop) && step && !start);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StStop;
      a_q         <= '0;
      b_q         <= '0;
      cflag_q     <= 1'b0;
      pc_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (exec) begin
        pc_q <= pc_next;
        if (wr_a) a_q <= sum[DATA_W-1:0];
        if (wr_b) b_q <= sum[DATA_W-1:0];
        if (is_out) begin
          out_q       <= sum[DATA_W-1:0];
          out_valid_q <= 1'b1;
        end
        if (is_nop) cflag_q <= 1'b0;
        else if (!is_hlt) cflag_q <= sum[DATA_W];
      end
      case (state_q)
        StRun: begin
          if (stop) state_q <= StStop;
          else if (is_hlt) state_q <= StHalted;
        end
        StStop: begin
          if (start) state_q <= StRun;
          else if (step && is_hlt) state_q <= StHalted;
        end
        StHalted: begin
          if (start) state_q <= StRun;
        end
        default: state_q <= StStop;
      endcase
    end
  end

  // Memory survives reset; writes are locked out while running.
  always_ff @(posedge clock) begin
    if (prog_we && (state_q != StRun)) mem[prog_addr] <= prog_data;
  end

  assign out_port  = out_q;
  assign out_valid = out_valid_q;
  assign pc        = pc_q;
  assign cflag     = cflag_q;
  assign state     = state_q;

endmodule

// File: tb/tb_td4n_core.sv
// Directed bench for td4n_core: a 4-bit instance for the ISA and control paths,
// plus an 8-bit/64-word instance for wide arithmetic and reset during RUN.
module tb_td4n_core;

  logic       clock = 1'b0;
  logic       reset, start, stop, step, prog_we;
  logic [3:0] prog_addr, in_port, out_port, pc;
  logic [7:0] prog_data;
  logic       out_valid, cflag;
  logic [1:0] state;

  logic        w_reset, w_start, w_stop, w_step, w_prog_we;
  logic [5:0]  w_prog_addr, w_pc;
  logic [11:0] w_prog_data;
  logic [7:0]  w_in_port, w_out_port;
  logic        w_out_valid, w_cflag;
  logic [1:0]  w_state;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  td4n_core #(.DATA_W(4), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .step(step),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .in_port(in_port),
    .out_port(out_port), .out_valid(out_valid), .pc(pc), .cflag(cflag), .state(state)
  );

  td4n_core #(.DATA_W(8), .ADDR_W(6)) dut_w (
    .clock(clock), .reset(w_reset), .start(w_start), .stop(w_stop), .step(w_step),
    .prog_we(w_prog_we), .prog_addr(w_prog_addr), .prog_data(w_prog_data),
    .in_port(w_in_port), .out_port(w_out_port), .out_valid(w_out_valid), .pc(w_pc),
    .cflag(w_cflag), .state(w_state)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic wr_w(input logic [5:0] a, input logic [11:0] d);
    w_prog_we = 1'b1; w_prog_addr = a; w_prog_data = d;
    tick();
    w_prog_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; in_port = 4'd0;
    w_reset = 1'b1; w_start = 1'b0; w_stop = 1'b0; w_step = 1'b0; w_prog_we = 1'b0;
    w_prog_addr = '0; w_prog_data = '0; w_in_port = 8'd0;
    tick();
    reset = 1'b0; w_reset = 1'b0;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_out", 32'(out_port), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cflag", 32'(cflag), 32'd0);

    // T1: MOV A,3; ADD A,14; MOV B,A; OUT B; HLT
    wr(4'd0, 8'h33); wr(4'd1, 8'hE0); wr(4'd2, 8'h04); wr(4'd3, 8'h09); wr(4'd4, 8'h08);
    check("stop_no_exec_pc", 32'(pc), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("t1_run", 32'(state), 32'd1);
    check("t1_pc0", 32'(pc), 32'd0);
    tick();
    check("t1_mov_c", 32'(cflag), 32'd0);
    tick();
    check("t1_add_c", 32'(cflag), 32'd1);
    check("t1_add_pc", 32'(pc), 32'd2);
    tick();
    check("t1_movba_c", 32'(cflag), 32'd0);
    tick();
    check("t1_outb", 32'(out_port), 32'd1);
    check("t1_outb_v", 32'(out_valid), 32'd1);
    tick();
    check("t1_hlt_state", 32'(state), 32'd2);
    check("t1_hlt_pc", 32'(pc), 32'd5);
    check("t1_hlt_v", 32'(out_valid), 32'd0);

    // T4/T2/T3: program while HALTED, resume after HLT
    wr(4'd5, 8'h9B); wr(4'd6, 8'hF0); wr(4'd7, 8'hCE); wr(4'd8, 8'hAE);
    wr(4'd9, 8'h08); wr(4'd10, 8'h08);
    check("halt_hold_pc", 32'(pc), 32'd5);
    start = 1'b1; tick(); start = 1'b0;
    check("resume_pc", 32'(pc), 32'd5);
    tick();
    check("t3_out9", 32'(out_port), 32'd9);
    check("t3_out9_v", 32'(out_valid), 32'd1);
    tick();
    check("t3_v_1cyc", 32'(out_valid), 32'd0);
    check("t2_add_c", 32'(cflag), 32'd1);
    check("t3_out_hold", 32'(out_port), 32'd9);
    tick();
    check("t2_jnc_nt_pc", 32'(pc), 32'd8);
    check("t2_jnc_nt_c", 32'(cflag), 32'd0);
    tick();
    check("t2_jnc_t_pc", 32'(pc), 32'd10);
    tick();
    check("t2_hlt_state", 32'(state), 32'd2);
    check("t2_hlt_pc", 32'(pc), 32'd11);

    // step in HALTED is ignored
    step = 1'b1; tick(); step = 1'b0;
    check("halt_step_pc", 32'(pc), 32'd11);
    check("halt_step_st", 32'(state), 32'd2);

    // T5: ADD B,1; OUT B; JMP 11 loop
    wr(4'd11, 8'h15); wr(4'd12, 8'h09); wr(4'd13, 8'hBF);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("loop_out", 32'(out_port), 32'd2);
    tick();
    check("jmp_pc", 32'(pc), 32'd11);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_state", 32'(state), 32'd0);
    check("stop_no_exec", 32'(pc), 32'd11);
    step = 1'b1; tick(); tick(); tick(); step = 1'b0;
    check("step3_pc", 32'(pc), 32'd11);
    check("step3_out", 32'(out_port), 32'd3);
    tick();
    check("step_idle_pc", 32'(pc), 32'd11);

    // prog_we during RUN must not land
    start = 1'b1; tick(); start = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd12; prog_data = 8'h08;
    tick(); tick();
    prog_we = 1'b0;
    check("we_run_out", 32'(out_port), 32'd4);
    check("we_run_v", 32'(out_valid), 32'd1);
    check("we_run_state", 32'(state), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop2_pc", 32'(pc), 32'd13);

    // pc wrap 15 -> 0 through OUT 7 and two NOPs
    wr(4'd13, 8'h7B); wr(4'd14, 8'h0C); wr(4'd15, 8'h0C);
    step = 1'b1; tick(); tick(); tick(); step = 1'b0;
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_out", 32'(out_port), 32'd7);

    // start and stop together: start wins in STOP, stop wins in RUN
    start = 1'b1; stop = 1'b1; step = 1'b1; tick();
    check("ss_stop_to_run", 32'(state), 32'd1);
    check("ss_step_ignored", 32'(pc), 32'd0);
    step = 1'b0; tick();
    check("ss_run_to_stop", 32'(state), 32'd0);
    check("ss_run_no_exec", 32'(pc), 32'd0);
    start = 1'b0; stop = 1'b0;

    // reset mid-RUN, memory kept
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("pre_rst_pc", 32'(pc), 32'd2);
    check("pre_rst_c", 32'(cflag), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_out", 32'(out_port), 32'd0);
    check("midrst_c", 32'(cflag), 32'd0);
    step = 1'b1; tick(); tick(); step = 1'b0;
    check("mem_kept_c", 32'(cflag), 32'd1);

    // IN B with imm, then OUT B
    in_port = 4'd6;
    wr(4'd2, 8'h16);
    step = 1'b1; tick(); tick(); step = 1'b0;
    check("in_b_out", 32'(out_port), 32'd7);

    // T6 wide: MOV A,100; ADD A,200; MOV B,A; OUT B; HLT
    wr_w(6'd0, {8'd100, 4'b0011}); wr_w(6'd1, {8'd200, 4'b0000});
    wr_w(6'd2, {8'd0, 4'b0100});   wr_w(6'd3, {8'd0, 4'b1001});
    wr_w(6'd4, {8'd0, 4'b1000});
    w_start = 1'b1; tick(); w_start = 1'b0;
    tick(); tick();
    check("w_add_c", 32'(w_cflag), 32'd1);
    tick(); tick();
    check("w_out", 32'(w_out_port), 32'd44);
    check("w_out_v", 32'(w_out_valid), 32'd1);
    check("w_pc", 32'(w_pc), 32'd4);
    w_reset = 1'b1; tick(); w_reset = 1'b0;
    check("w_rst_pc", 32'(w_pc), 32'd0);
    check("w_rst_out", 32'(w_out_port), 32'd0);
    check("w_rst_state", 32'(w_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
